// File: rtl/keyboard_letter_queue.sv
// keyboard_letter_queue
// Parses PS/2 scan bytes (make / break / extended prefixes) and maps A-Z and
// Enter make codes to letter indices. Held-key typematic repeats can be
// suppressed. Decoded letters are buffered in a show-ahead FIFO, and the game
// FSM pops them from that FIFO.
module keyboard_letter_queue #(
  parameter int FIFO_DEPTH   = 4,
  parameter int ALLOW_REPEAT = 0
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic                            byte_valid,
  input  logic [7:0]                      byte_data,
  input  logic                            clear,
  input  logic                            pop,
  output logic                            letter_valid,
  output logic [4:0]                      letter,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] fifo_count,
  output logic                            overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

  localparam logic [7:0] BRK_PREFIX = 8'hF0;
  localparam logic [7:0] EXT_PREFIX = 8'hE0;
  localparam logic [4:0] EMPTY_IDX  = 5'd27;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_BRK     = 2'd1,
    ST_EXT     = 2'd2,
    ST_EXT_BRK = 2'd3
  } parse_state_t;

  parse_state_t     state_q;
  logic             held_valid_q;
  logic [7:0]       held_code_q;

  logic [4:0]       mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;

  logic             dec_hit;
  logic [4:0]       dec_idx;
  logic             push_req;
  logic             fifo_empty;
  logic             fifo_full;
  logic             pop_eff;
  logic             push_eff;

  // Make-code to letter index. The top bit flags a mapped code.
  function automatic logic [5:0] decode_make(input logic [7:0] code);
    logic [5:0] r;
    case (code)
      8'h1C: r = {1'b1, 5'd0};
      8'h32: r = {1'b1, 5'd1};
      8'h21: r = {1'b1, 5'd2};
      8'h23: r = {1'b1, 5'd3};
      8'h24: r = {1'b1, 5'd4};
      8'h2B: r = {1'b1, 5'd5};
      8'h34: r = {1'b1, 5'd6};
      8'h33: r = {1'b1, 5'd7};
      8'h43: r = {1'b1, 5'd8};
      8'h3B: r = {1'b1, 5'd9};
      8'h42: r = {1'b1, 5'd10};
      8'h4B: r = {1'b1, 5'd11};
      8'h3A: r = {1'b1, 5'd12};
      8'h31: r = {1'b1, 5'd13};
      8'h44: r = {1'b1, 5'd14};
      8'h4D: r = {1'b1, 5'd15};
      8'h15: r = {1'b1, 5'd16};
      8'h2D: r = {1'b1, 5'd17};
      8'h1B: r = {1'b1, 5'd18};
      8'h2C: r = {1'b1, 5'd19};
      8'h3C: r = {1'b1, 5'd20};
      8'h2A: r = {1'b1, 5'd21};
      8'h1D: r = {1'b1, 5'd22};
      8'h22: r = {1'b1, 5'd23};
      8'h35: r = {1'b1, 5'd24};
      8'h1A: r = {1'b1, 5'd25};
      8'h5A: r = {1'b1, 5'd26};
      default: r = {1'b0, 5'd0};
    endcase
    return r;
  endfunction

  // Push decision and FIFO occupancy flags.
  always_comb begin
    {dec_hit, dec_idx} = decode_make(byte_data);
    push_req   = 1'b0;
    if (byte_valid && (state_q == ST_IDLE) &&
        (byte_data != BRK_PREFIX) && (byte_data != EXT_PREFIX) && dec_hit) begin
      // A repeat of the currently held key is swallowed unless repeats are allowed.
      push_req = (ALLOW_REPEAT != 0) || !held_valid_q || (byte_data != held_code_q);
    end
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == CNT_W'(FIFO_DEPTH));
    pop_eff    = pop && !fifo_empty;
    // When full, a push only fits if the head leaves in the same cycle.
    push_eff   = push_req && (!fifo_full || pop_eff);
  end

  // Parser FSM: advances on each received byte and tracks the held key.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      held_valid_q <= 1'b0;
      held_code_q  <= 8'h00;
    end else if (clear) begin
      state_q      <= ST_IDLE;
      held_valid_q <= 1'b0;
      held_code_q  <= 8'h00;
    end else if (byte_valid) begin
      case (state_q)
        ST_IDLE: begin
          if (byte_data == BRK_PREFIX) begin
            state_q <= ST_BRK;
          end else if (byte_data == EXT_PREFIX) begin
            state_q <= ST_EXT;
          end else if (dec_hit) begin
            // A newly pressed key supersedes whichever key was held before.
            held_valid_q <= 1'b1;
            held_code_q  <= byte_data;
          end
        end
        ST_BRK: begin
          if (held_valid_q && (byte_data == held_code_q)) begin
            held_valid_q <= 1'b0;
          end
          state_q <= ST_IDLE;
        end
        ST_EXT: begin
          state_q <= (byte_data == BRK_PREFIX) ? ST_EXT_BRK : ST_IDLE;
        end
        ST_EXT_BRK: begin
          state_q <= ST_IDLE;
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // FIFO pointer, count and overflow next-state.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    if (clear) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      if (push_eff) begin
        wr_ptr_d = wr_ptr_q + PTR_W'(1);
      end
      if (pop_eff) begin
        rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push_eff, pop_eff})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (push_req && !push_eff) begin
        overflow_d = 1'b1;
      end
    end
  end

  // FIFO control registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
    end
  end

  // FIFO storage. Entries are only read while counted as valid, so they need no reset.
  always_ff @(posedge clk) begin
    if (push_eff && !clear) begin
      mem_q[wr_ptr_q] <= dec_idx;
    end
  end

  assign letter_valid = !fifo_empty;
  assign letter       = fifo_empty ? EMPTY_IDX : mem_q[rd_ptr_q];
  assign fifo_count   = count_q;
  assign overflow     = overflow_q;

endmodule

// File: tb/tb_keyboard_letter_queue.sv
// Directed bench for keyboard_letter_queue.
// Two instances share one stimulus stream: u0 suppresses repeats and u1 allows them.
module tb_keyboard_letter_queue;

  logic       clk = 1'b0;
  logic       reset;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       clear;
  logic       pop;

  logic       lv0, lv1;
  logic [4:0] let0, let1;
  logic [2:0] cnt0, cnt1;
  logic       ovf0, ovf1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  keyboard_letter_queue #(.FIFO_DEPTH(4), .ALLOW_REPEAT(0)) u0 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .clear(clear), .pop(pop), .letter_valid(lv0), .letter(let0),
    .fifo_count(cnt0), .overflow(ovf0)
  );

  keyboard_letter_queue #(.FIFO_DEPTH(4), .ALLOW_REPEAT(1)) u1 (
    .clk(clk), .reset(reset), .byte_valid(byte_valid), .byte_data(byte_data),
    .clear(clear), .pop(pop), .letter_valid(lv1), .letter(let1),
    .fifo_count(cnt1), .overflow(ovf1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Drive one byte for one cycle; returns at the following falling edge.
  task automatic send(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    @(negedge clk);
    byte_valid = 1'b0;
  endtask

  task automatic do_pop();
    @(negedge clk);
    pop = 1'b1;
    @(negedge clk);
    pop = 1'b0;
  endtask

  task automatic send_and_pop(input logic [7:0] b);
    @(negedge clk);
    byte_valid = 1'b1;
    byte_data  = b;
    pop        = 1'b1;
    @(negedge clk);
    byte_valid = 1'b0;
    pop        = 1'b0;
  endtask

  task automatic do_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  initial begin
    reset = 1'b1; byte_valid = 1'b0; byte_data = 8'h00; clear = 1'b0; pop = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    // Reset state
    check("rst_valid", lv0, 0);
    check("rst_letter", let0, 27);
    check("rst_count", cnt0, 0);
    check("rst_ovf", ovf0, 0);

    // 1: 1C visible one cycle after the byte; the break adds nothing
    send(8'h1C);
    check("t1_valid", lv0, 1);
    check("t1_letter", let0, 0);
    check("t1_count", cnt0, 1);
    send(8'hF0);
    send(8'h1C);
    check("t1_count_after_brk", cnt0, 1);
    do_pop();
    check("t1_pop_valid", lv0, 0);
    check("t1_pop_letter", let0, 27);

    // 2: repeat suppression versus repeats allowed
    send(8'h1C); send(8'h1C); send(8'h1C);
    send(8'hF0); send(8'h1C);
    send(8'h1C); send(8'h1C);
    check("t2_norep_count", cnt0, 2);
    check("t2_norep_ovf", ovf0, 0);
    check("t2_rep_count", cnt1, 4);
    check("t2_rep_ovf", ovf1, 1);
    check("t2_rep_head", let1, 0);
    check("t2_head0", let0, 0);
    do_pop();
    check("t2_head1", let0, 0);
    check("t2_count_after_pop", cnt0, 1);
    do_clear();
    check("t2_clear_count", cnt0, 0);
    check("t2_clear_ovf1", ovf1, 0);

    // 3: extended keys ignored, Enter maps to 26, unmapped codes dropped
    send(8'hE0); send(8'h75); send(8'hE0); send(8'hF0); send(8'h75);
    check("t3_ext_count", cnt0, 0);
    send(8'h5A);
    check("t3_enter_count", cnt0, 1);
    check("t3_enter_letter", let0, 26);
    do_clear();
    send(8'hAA); send(8'hFA);
    check("t3_unmapped_count", cnt0, 0);
    check("t3_unmapped_valid", lv0, 0);

    // 4: overflow with FIFO_DEPTH=4 and push+pop while full
    send(8'h1C); send(8'h32); send(8'h21); send(8'h23); send(8'h24);
    check("t4_count", cnt0, 4);
    check("t4_head", let0, 0);
    check("t4_ovf", ovf0, 1);
    send_and_pop(8'h2B);
    check("t4_pp_count", cnt0, 4);
    check("t4_pp_head", let0, 1);
    do_pop(); check("t4_pop1", let0, 2);
    do_pop(); check("t4_pop2", let0, 3);
    do_pop(); check("t4_pop3", let0, 5);
    do_pop();
    check("t4_empty", lv0, 0);
    check("t4_ovf_sticky", ovf0, 1);
    do_clear();

    // 5: a released key other than the held one leaves B held
    send(8'h1C); send(8'h32); send(8'hF0); send(8'h1C); send(8'h32);
    check("t5_count2", cnt0, 2);
    send(8'hF0); send(8'h32); send(8'h32);
    check("t5_count3", cnt0, 3);
    check("t5_e0", let0, 0);
    do_pop(); check("t5_e1", let0, 1);
    do_pop(); check("t5_e2", let0, 1);
    do_clear();

    // 6: asynchronous reset after F0, then 1C counts as a make
    send(8'h1C);
    send(8'hF0);
    #2 reset = 1'b1;
    #1 check("t6_async_count", cnt0, 0);
    @(negedge clk);
    reset = 1'b0;
    send(8'h1C);
    check("t6_rst_make_count", cnt0, 1);
    check("t6_rst_make_letter", let0, 0);
    do_clear();
    // Clear after F0 behaves the same way
    send(8'hF0);
    do_clear();
    send(8'h1C);
    check("t6_clr_make_count", cnt0, 1);
    check("t6_clr_make_letter", let0, 0);
    // Clear wins over a byte and a pop issued in the same cycle
    @(negedge clk);
    clear = 1'b1; byte_valid = 1'b1; byte_data = 8'h32; pop = 1'b1;
    @(negedge clk);
    clear = 1'b0; byte_valid = 1'b0; pop = 1'b0;
    check("t6_clr_wins_count", cnt0, 0);
    check("t6_clr_wins_letter", let0, 27);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Watchdog so the run always terminates
  initial begin
    #200000;
    $display("FAIL watchdog timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
